rr_decode_arbiter: RTL and testbench
====================================

Name: rr_decode_arbiter

Overview:
- Round-robin arbiter sharing one 2-to-4 one-hot decode resource between 4 requesters.
- Picks one requester, holds the 2-bit index and drives the decoded one-hot grant until the owner releases it.
- Sits between 4 client blocks and the shared decoder-select path.
- Provides fair, starvation-free access with an optional hold timeout.

Parameters:
- MAX_HOLD, 15: maximum cycles a grant may be held before forced release. Only used when ARB_TIMEOUT_EN is defined. Range 1..255.
- CNT_W, 8: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request vector; bit i = requester i wants the resource. Level, held until granted.
- done  input  4  release pulse; bit i is honoured only while requester i is the owner.
- grant  output  4  registered one-hot grant. Decode of grant_idx when grant_valid=1, else 4'b0000.
- grant_idx  output  2  index of the current owner. Holds its last value when idle.
- grant_valid  output  1  high while any grant is active.
- timeout  output  1  one-cycle pulse when a grant is force-released. Tied to 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Outputs: grant=0000, grant_idx=00, grant_valid=0, timeout=0.
  - Internal: state=IDLE, last pointer=3 (so requester 0 has first priority), hold counter=0.
- Reset mid-grant drops the grant on the next edge; no done is required.
- FSM states: IDLE, GRANT.
- IDLE:
  - If req != 0, select the first set bit searching upward from (last+1) mod 4, wrapping 3→0.
  - On the next edge: set grant_idx to the winner, grant_valid=1, grant=decode(idx), last=idx, counter=0, go to GRANT.
  - If req == 0, stay in IDLE.
- Latency: req rising at edge t gives grant visible after edge t+1.
- GRANT, release conditions (any one suffices):
  - done[idx]=1, or
  - req[idx]=0 (requester withdrew), or
  - counter==MAX_HOLD-1 (timeout build only).
- On release: next edge clears grant and grant_valid and returns to IDLE. This gives one mandatory idle cycle between owners.
- Back-to-back: the earliest next grant is 2 edges after the release condition.
- Counter increments each GRANT cycle and saturates; it is never observable externally.
- done bits for non-owners are ignored. done while in IDLE is ignored.
- Simultaneous done and timeout on the same cycle: treated as a normal release, timeout=0.
- New requests arriving during GRANT are not evaluated until IDLE.
- Priority: the owner just served becomes lowest priority. Any continuously requesting client is granted within 3 other grants.
- grant is always a pure function of the registered grant_idx and grant_valid, so it is never combinationally dependent on req.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - Hold counter and MAX_HOLD release are compiled in.
  - timeout pulses for 1 cycle on the release edge, together with grant going low.
- Undefined:
  - No counter logic; a grant is held indefinitely until done[idx] or req[idx] drops.
  - timeout is constant 0.

Decomposition:
- Shared package (rr_decode_pkg):
  - State encoding localparams: ST_IDLE=1'b0, ST_GRANT=1'b1.
  - NUM_REQ=4 and IDX_W=2.
  - Reset pointer constant LAST_RST=2'd3.
- One sub-module: onehot_decode2to4.
  - Combinational, 2-bit idx plus enable in, 4-bit one-hot out.
  - Instanced once to produce grant from the registered index and valid.

Test Plan:
- Reset then req=0001 → grant=0001, idx=0 one cycle later. Pulse done=0001 → grant=0000 next cycle, grant_valid=0.
- req=1111 held, done pulsed by each owner → grant sequence 0001, 0010, 0100, 1000, 0001 (wrap), with one idle cycle between each.
- Owner 2 holds; req=0101 with done=0001 (non-owner) → ignored, grant stays 0100. Then req[2] drops → release. Next grant goes to requester 0 (search from 3, wraps to 0).
- ARB_TIMEOUT_EN, MAX_HOLD=4: req=0010 held, no done → grant=0010 for exactly 4 cycles. timeout=1 for one cycle as the grant clears. Requester 1 is re-granted after the idle cycle.
- rst asserted on the 2nd cycle of a grant → next edge grant=0000, grant_valid=0, pointer=3. With req=1010 held, the first grant after rst deasserts is 0010.
- ARB_TIMEOUT_EN: done[idx] and the timeout condition on the same cycle → release with timeout=0.

Source files
------------

// File: rtl/rr_decode_pkg.sv
// Shared types and constants for the round-robin decode arbiter.
package rr_decode_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  localparam logic [IDX_W-1:0] LAST_RST = 2'd3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // First requester at or after last+1, wrapping; the previous owner is checked last.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] cand;
    logic             found;
    rr_pick = last;
    found   = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = last + IDX_W'(k);
      if (!found && req[cand]) begin
        rr_pick = cand;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/onehot_decode2to4.sv
// Combinational 2-to-4 one-hot decoder with enable.
module onehot_decode2to4
  import rr_decode_pkg::*;
(
  input  logic [IDX_W-1:0]   idx,
  input  logic               en,
  output logic [NUM_REQ-1:0] onehot
);

  always_comb begin
    // NOTE: default assignment first so no path leaves onehot unassigned (no latch).
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for one shared 2-to-4 decode resource among 4 requesters.
// Optional hold timeout compiled in with `define ARB_TIMEOUT_EN.
module rr_decode_arbiter
  import rr_decode_pkg::*;
#(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid,
  output logic               timeout
);

  localparam bit PARAMS_OK = (MAX_HOLD >= 1) && (MAX_HOLD <= 255) &&
                             (CNT_W < 31) && ((2 ** CNT_W) > MAX_HOLD);

  if (!PARAMS_OK) begin : g_bad_params
    $error("rr_decode_arbiter: MAX_HOLD must be 1..255 and fit in CNT_W bits");
  end

  state_t           state;
  logic [IDX_W-1:0] last_idx;
  logic             owner_done;
  logic             owner_drop;
  logic             hold_expired;
  logic             release_now;

  assign owner_done  = done[grant_idx];
  assign owner_drop  = ~req[grant_idx];
  assign release_now = owner_done | owner_drop | hold_expired;

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] hold_cnt;

  assign hold_expired = (hold_cnt == HOLD_LAST);

  // Cleared during the mandatory idle cycle, so every grant starts counting from 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      if (state == ST_IDLE)    hold_cnt <= '0;
      else if (hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
      timeout <= (state == ST_GRANT) && hold_expired && !owner_done && !owner_drop;
    end
  end
`else
  assign hold_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      last_idx    <= LAST_RST;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            grant_idx   <= rr_pick(req, last_idx);
            last_idx    <= rr_pick(req, last_idx);
            grant_valid <= 1'b1;
            state       <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (release_now) begin
            grant_valid <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  onehot_decode2to4 u_decode (
    .idx    (grant_idx),
    .en     (grant_valid),
    .onehot (grant)
  );

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Self-checking bench for rr_decode_arbiter: directed scenarios plus random traffic
// against a cycle-level reference model of the arbitration rules.
module tb_rr_decode_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // Reference model: owner, last served, and how many cycles the grant has been visible.
  bit m_valid;
  int m_idx;
  int m_last;
  int m_held;
  bit m_timeout;

  rr_decode_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] m_grant();
    return m_valid ? 4'(1 << m_idx) : 4'b0000;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_valid = 0; m_idx = 0; m_last = 3; m_held = 0; m_timeout = 0;
    end else if (!m_valid) begin
      m_timeout = 0;
      for (int k = 1; k <= 4; k++) begin
        if (!m_valid && req[(m_last + k) % 4]) begin
          m_idx   = (m_last + k) % 4;
          m_last  = m_idx;
          m_valid = 1;
          m_held  = 1;
        end
      end
    end else begin
      bit by_done, by_drop, by_time;
      by_done = done[m_idx];
      by_drop = !req[m_idx];
      by_time = TO_EN && (m_held >= MAX_HOLD);
      m_timeout = by_time && !by_done && !by_drop;
      if (by_done || by_drop || by_time) m_valid = 0;
      else m_held++;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; req = '0; done = '0;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; req = 4'b1111; done = 4'b1111;
    tick();
    checks++;
    if (grant !== 4'b0000 || grant_idx !== 2'd0 || grant_valid !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset: got grant=%b idx=%0d valid=%b timeout=%b want 0000/0/0/0",
               grant, grant_idx, grant_valid, timeout);
    end
    rst = 0; req = '0; done = '0;
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0001;
    tick();
    checks++;
    if (grant !== 4'b0001 || grant_idx !== 2'd0 || grant_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: got grant=%b idx=%0d valid=%b want 0001/0/1",
               grant, grant_idx, grant_valid);
    end
    done = 4'b0001;
    tick();
    done = '0; req = '0;
    checks++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_idx !== 2'd0) begin
      errors++;
      $display("FAIL single_release: got grant=%b idx=%0d valid=%b want 0000/0/0",
               grant, grant_idx, grant_valid);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (grant !== exp_seq[k]) begin
        errors++;
        $display("FAIL rotation_grant[%0d]: got %b want %b", k, grant, exp_seq[k]);
      end
      done = grant;
      tick();
      done = '0;
      checks++;
      if (grant !== 4'b0000 || grant_valid !== 1'b0) begin
        errors++;
        $display("FAIL rotation_idle[%0d]: got grant=%b valid=%b want 0000/0", k, grant, grant_valid);
      end
    end
    req = '0;
    tick();
  endtask

  task automatic test_nonowner_done();
    do_reset();
    req = 4'b0100;
    tick();
    req = 4'b0101; done = 4'b0001;
    tick();
    checks++;
    if (grant !== 4'b0100 || grant_idx !== 2'd2) begin
      errors++;
      $display("FAIL nonowner_done: got grant=%b idx=%0d want 0100/2", grant, grant_idx);
    end
    done = '0; req = 4'b0001;
    tick();
    checks++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_idx !== 2'd2) begin
      errors++;
      $display("FAIL withdraw_release: got grant=%b valid=%b idx=%0d want 0000/0/2",
               grant, grant_valid, grant_idx);
    end
    tick();
    checks++;
    if (grant !== 4'b0001 || grant_idx !== 2'd0) begin
      errors++;
      $display("FAIL wrap_to_0: got grant=%b idx=%0d want 0001/0", grant, grant_idx);
    end
    req = '0;
    tick();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 4'b1010;
    tick();
    tick();
    rst = 1;
    tick();
    checks++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_idx !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_grant: got grant=%b valid=%b idx=%0d want 0000/0/0",
               grant, grant_valid, grant_idx);
    end
    rst = 0;
    tick();
    checks++;
    if (grant !== 4'b0010 || grant_idx !== 2'd1) begin
      errors++;
      $display("FAIL post_reset_grant: got grant=%b idx=%0d want 0010/1", grant, grant_idx);
    end
    req = '0;
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    req = 4'b0010;
    for (int c = 1; c <= MAX_HOLD; c++) begin
      tick();
      checks++;
      if (grant !== 4'b0010 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle[%0d]: got grant=%b timeout=%b want 0010/0", c, grant, timeout);
      end
    end
    tick();
    checks++;
    if (TO_EN) begin
      if (grant !== 4'b0000 || timeout !== 1'b1) begin
        errors++;
        $display("FAIL timeout_release: got grant=%b timeout=%b want 0000/1", grant, timeout);
      end
    end else if (grant !== 4'b0010 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL hold_forever: got grant=%b timeout=%b want 0010/0", grant, timeout);
    end
    tick();
    checks++;
    if (grant !== 4'b0010 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL regrant_after_timeout: got grant=%b timeout=%b want 0010/0", grant, timeout);
    end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_done_with_timeout();
    do_reset();
    req = 4'b0010;
    for (int c = 1; c <= MAX_HOLD; c++) tick();
    done = 4'b0010;
    tick();
    done = '0;
    checks++;
    if (grant !== 4'b0000 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL done_and_timeout: got grant=%b timeout=%b want 0000/0", grant, timeout);
    end
    req = '0;
    tick();
  endtask

  task automatic test_random();
    int bad = 0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst  = ($urandom_range(0, 49) == 0);
      req  = 4'($urandom);
      done = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      tick();
      checks++;
      if (grant !== m_grant() || grant_valid !== m_valid || grant_idx !== 2'(m_idx) ||
          timeout !== m_timeout) begin
        errors++;
        if (bad++ < 10)
          $display("FAIL random[%0d]: got grant=%b idx=%0d valid=%b to=%b want %b/%0d/%b/%b",
                   c, grant, grant_idx, grant_valid, timeout, m_grant(), m_idx, m_valid, m_timeout);
      end
    end
    rst = 0; req = '0; done = '0;
  endtask

  initial begin
    rst = 1; req = '0; done = '0;
    m_valid = 0; m_idx = 0; m_last = 3; m_held = 0; m_timeout = 0;
    test_reset();
    test_single();
    test_rotation();
    test_nonowner_done();
    test_reset_mid_grant();
    test_timeout();
    test_done_with_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
